// File: rtl/spill_splitter.sv
// spill_splitter: replays spilled task blocks to the tile task queue and
// returns fully drained chunks to the shared splitter stack.
module spill_splitter #(
  parameter int TILE_ID                  = 0,
  parameter int TQ_WIDTH                 = 100,
  parameter int LOG_ENTRY_WIDTH          = 7,
  parameter int TASKS_PER_SPLITTER       = 8,
  parameter int LOG_SPLITTERS_PER_CHUNK  = 3,
  parameter int LOG_SPLITTER_CHUNK_WIDTH = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [37:0]                     spill_base,
  input  logic [37:0]                     stack_base,
  input  logic [37:0]                     scratch_base,
  input  logic [37:0]                     stack_ptr_addr,
  input  logic                            task_in_valid,
  output logic                            task_in_ready,
  input  logic [31:0]                     task_in_locale,
  output logic                            arvalid,
  input  logic                            arready,
  output logic [63:0]                     araddr,
  output logic [7:0]                      arlen,
  output logic [2:0]                      arsize,
  input  logic                            rvalid,
  output logic                            rready,
  input  logic [(1<<LOG_ENTRY_WIDTH)-1:0] rdata,
  input  logic                            rlast,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [63:0]                     awaddr,
  output logic [2:0]                      awsize,
  output logic                            wvalid,
  input  logic                            wready,
  output logic [15:0]                     wdata,
  output logic                            wlast,
  input  logic                            bvalid,
  output logic                            bready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TQ_WIDTH-1:0]             out_task,
  output logic                            stack_lock_out,
  input  logic                            stack_lock_in,
  output logic                            busy
);
  localparam int EW = 1 << LOG_ENTRY_WIDTH;

  typedef enum logic [3:0] {
    IDLE, RD_BLOCK, STREAM, SCR_RD, SCR_RD_W, SCR_WR, SCR_WR_B,
    GRAB_LOCK, CHECK_LOCK, RD_PTR, RD_PTR_W, WR_ENTRY, WR_ENTRY_B,
    WR_PTR, WR_PTR_B, RELEASE
  } state_t;

  state_t      r_state, w_nxt;
  logic [15:0] r_coal_id, r_cnt, r_ptr;
  logic        r_lock, r_awd, r_wd;

  logic [15:0] w_chunk, w_cnt_inc, w_ptr_dec;
  logic [37:0] w_spill_addr, w_scr_addr, w_ent_addr;
  logic        w_wrap, w_pad, w_wr_st, w_wr_done, w_lock_nxt;
  logic        w_unused;

  assign w_chunk      = r_coal_id >> LOG_SPLITTERS_PER_CHUNK;
  assign w_cnt_inc    = r_cnt + 16'd1;
  assign w_wrap       = w_cnt_inc == 16'(1 << LOG_SPLITTERS_PER_CHUNK);
  assign w_ptr_dec    = r_ptr - 16'd1;
  assign w_spill_addr = spill_base
                      + (38'(r_coal_id) << LOG_SPLITTER_CHUNK_WIDTH);
  assign w_scr_addr   = scratch_base + {21'd0, w_chunk, 1'b0};
  assign w_ent_addr   = stack_base + {21'd0, w_ptr_dec, 1'b0};
  assign w_pad        = rdata[TQ_WIDTH];
  assign w_wr_st      = r_state inside {SCR_WR, WR_ENTRY, WR_PTR};
  assign w_wr_done    = (r_awd | awready) & (r_wd | wready);
  assign w_lock_nxt   = w_nxt inside {CHECK_LOCK, RD_PTR, RD_PTR_W,
                        WR_ENTRY, WR_ENTRY_B, WR_PTR, WR_PTR_B, RELEASE};
  assign w_unused     = ^{rdata[EW-1:TQ_WIDTH+1], task_in_locale[15:0],
                          32'(TILE_ID)};

  assign stack_lock_out = r_lock & ~rst;
  assign busy           = ~rst & (r_state != IDLE);

  always_comb begin
    w_nxt         = r_state;
    task_in_ready = 1'b0;
    arvalid       = 1'b0;
    araddr        = 64'd0;
    arlen         = 8'd0;
    arsize        = 3'd0;
    rready        = 1'b0;
    awvalid       = 1'b0;
    awaddr        = 64'd0;
    awsize        = 3'd0;
    wvalid        = 1'b0;
    wdata         = 16'd0;
    wlast         = 1'b0;
    bready        = 1'b0;
    out_valid     = 1'b0;
    out_task      = '0;
    if (!rst) begin
      if (w_wr_st) begin
        awvalid = ~r_awd;
        wvalid  = ~r_wd;
        awsize  = 3'd1;
        wlast   = 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          task_in_ready = start;
          if (start && task_in_valid) w_nxt = RD_BLOCK;
        end
        RD_BLOCK: begin
          arvalid = 1'b1;
          araddr  = 64'(w_spill_addr);
          arlen   = 8'(TASKS_PER_SPLITTER - 1);
          arsize  = 3'(LOG_ENTRY_WIDTH - 3);
          if (arready) w_nxt = STREAM;
        end
        STREAM: begin
          // pads are consumed without waiting on the task queue
          out_valid = rvalid & ~w_pad;
          out_task  = rdata[TQ_WIDTH-1:0];
          rready    = w_pad | out_ready;
          if (rvalid && (w_pad || out_ready) && rlast) w_nxt = SCR_RD;
        end
        SCR_RD: begin
          arvalid = 1'b1;
          araddr  = 64'(w_scr_addr);
          arsize  = 3'd1;
          if (arready) w_nxt = SCR_RD_W;
        end
        SCR_RD_W: begin
          rready = 1'b1;
          if (rvalid) w_nxt = SCR_WR;
        end
        SCR_WR: begin
          awaddr = 64'(w_scr_addr);
          wdata  = w_wrap ? 16'd0 : w_cnt_inc;
          if (w_wr_done) w_nxt = SCR_WR_B;
        end
        SCR_WR_B: begin
          bready = 1'b1;
          if (bvalid) w_nxt = w_wrap ? GRAB_LOCK : IDLE;
        end
        GRAB_LOCK: if (!stack_lock_in) w_nxt = CHECK_LOCK;
        CHECK_LOCK: w_nxt = RD_PTR;
        RD_PTR: begin
          arvalid = 1'b1;
          araddr  = 64'(stack_ptr_addr);
          arsize  = 3'd1;
          if (arready) w_nxt = RD_PTR_W;
        end
        RD_PTR_W: begin
          rready = 1'b1;
          if (rvalid) w_nxt = WR_ENTRY;
        end
        WR_ENTRY: begin
          awaddr = 64'(w_ent_addr);
          wdata  = w_chunk;
          if (w_wr_done) w_nxt = WR_ENTRY_B;
        end
        WR_ENTRY_B: begin
          bready = 1'b1;
          if (bvalid) w_nxt = WR_PTR;
        end
        WR_PTR: begin
          awaddr = 64'(stack_ptr_addr);
          wdata  = w_ptr_dec;
          if (w_wr_done) w_nxt = WR_PTR_B;
        end
        WR_PTR_B: begin
          bready = 1'b1;
          if (bvalid) w_nxt = RELEASE;
        end
        RELEASE: w_nxt = IDLE;
        default: w_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lock    <= 1'b0;
      r_awd     <= 1'b0;
      r_wd      <= 1'b0;
      r_coal_id <= 16'd0;
      r_cnt     <= 16'd0;
      r_ptr     <= 16'd0;
    end else begin
      r_state <= w_nxt;
      r_lock  <= w_lock_nxt;
      // aw and w may complete on different cycles
      if (w_wr_st && !w_wr_done) begin
        r_awd <= r_awd | awready;
        r_wd  <= r_wd | wready;
      end else begin
        r_awd <= 1'b0;
        r_wd  <= 1'b0;
      end
      if (r_state == IDLE && start && task_in_valid)
        r_coal_id <= task_in_locale[31:16];
      if (r_state == SCR_RD_W && rvalid) r_cnt <= rdata[15:0];
      if (r_state == RD_PTR_W && rvalid) r_ptr <= rdata[15:0];
    end
  end
endmodule

// File: tb/tb_spill_splitter.sv
// tb_spill_splitter: memory/queue model with an output scoreboard
// driving spill_splitter through its splitter and stack-push flows.
module tb_spill_splitter;
  localparam logic [37:0] SPILL = 38'h10_0000;
  localparam logic [37:0] STACK = 38'h20_0000;
  localparam logic [37:0] SCR   = 38'h30_0000;
  localparam logic [37:0] PTR   = 38'h40_0000;

  logic clk = 0, rst = 1, start = 0;
  logic task_in_valid = 0, task_in_ready;
  logic [31:0] task_in_locale = 0;
  logic arvalid, arready = 0, rready, rvalid = 0, rlast = 0;
  logic [63:0] araddr, awaddr;
  logic [7:0] arlen;
  logic [2:0] arsize, awsize;
  logic [127:0] rdata = '0;
  logic awvalid, awready = 0, wvalid, wready = 0, wlast;
  logic [15:0] wdata;
  logic bvalid = 0, bready;
  logic out_valid, out_ready = 1;
  logic [99:0] out_task;
  logic stack_lock_out, stack_lock_in = 0, busy;

  int checks = 0, failures = 0;
  logic [99:0] exp_q[$];
  logic [99:0] exp_t;
  logic [127:0] spill_mem[longint];
  logic [15:0] mem16[longint];

  bit rd_busy, rd_spill, aw_got, w_got, b_pend;
  bit lock_seen, ent_aw, tog_en;
  longint rd_addr, aw_a;
  int rd_len, rd_beat, b_wait, b_delay = 0;
  logic [15:0] w_d;
  int ar_cnt, aw_cnt, emit_cnt, viol;
  logic [63:0] sp_araddr;
  logic [7:0] sp_arlen;
  logic [2:0] sp_arsize;

  spill_splitter dut (
    .clk(clk), .rst(rst), .start(start),
    .spill_base(SPILL), .stack_base(STACK),
    .scratch_base(SCR), .stack_ptr_addr(PTR),
    .task_in_valid(task_in_valid), .task_in_ready(task_in_ready),
    .task_in_locale(task_in_locale),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awsize(awsize), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wlast(wlast), .bvalid(bvalid), .bready(bready),
    .out_valid(out_valid), .out_ready(out_ready), .out_task(out_task),
    .stack_lock_out(stack_lock_out), .stack_lock_in(stack_lock_in),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] read_beat(longint a, int b);
    longint idx;
    if (a >= SPILL && a < STACK) begin
      idx = (a - SPILL) / 16 + b;
      if (spill_mem.exists(idx)) return spill_mem[idx];
      return {27'd0, 1'b1, 100'd0};
    end
    return {112'd0, mem16.exists(a) ? mem16[a] : 16'd0};
  endfunction

  function automatic bit is_stack(longint a);
    return (a >= STACK && a < STACK + 'h10000) || a == PTR;
  endfunction

  // memory model and scoreboard: drive at negedge, resolve handshakes at +1
  always @(negedge clk) begin
    if (rst) begin
      rd_busy = 0; aw_got = 0; w_got = 0; b_pend = 0;
    end else if (b_pend && b_wait > 0) b_wait--;
    arready = !rst && !rd_busy;
    rvalid  = !rst && rd_busy;
    rdata   = rvalid ? read_beat(rd_addr, rd_beat) : '0;
    rlast   = rvalid && rd_beat == rd_len;
    awready = !rst && !aw_got;
    wready  = !rst && !w_got;
    bvalid  = !rst && b_pend && b_wait == 0;
    out_ready = tog_en ? !out_ready : 1'b1;
    #1;
    if (!rst) begin
      if (stack_lock_out) lock_seen = 1;
      checks++;
      if (rvalid && rd_spill) begin
        if (rready !== (rdata[100] | out_ready) || out_valid !== !rdata[100]) begin
          failures++;
          $display("FAIL stream_hs rready=%b out_valid=%b pad=%b out_ready=%b",
                   rready, out_valid, rdata[100], out_ready);
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stray_out_valid got=%b exp=0", out_valid);
      end
      if (out_valid && out_ready) begin
        emit_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_task unexpected got=%h", out_task);
        end else begin
          exp_t = exp_q.pop_front();
          if (out_task !== exp_t) begin
            failures++;
            $display("FAIL out_task got=%h exp=%h", out_task, exp_t);
          end
        end
      end
      if (rvalid && rready) begin
        if (rd_beat == rd_len) rd_busy = 0;
        else rd_beat++;
      end
      if (arvalid && arready) begin
        ar_cnt++; rd_busy = 1; rd_addr = longint'(araddr);
        rd_len = int'(arlen); rd_beat = 0;
        rd_spill = araddr >= SPILL && araddr < STACK;
        if (rd_spill) begin
          sp_araddr = araddr; sp_arlen = arlen; sp_arsize = arsize;
        end
        if (is_stack(longint'(araddr)) && !stack_lock_out) viol++;
      end
      if (awvalid && awready) begin
        aw_cnt++; aw_got = 1; aw_a = longint'(awaddr);
        if (is_stack(aw_a) && !stack_lock_out) viol++;
        if (aw_a >= SCR && aw_a < SCR + 'h10000 && stack_lock_out) viol++;
        if (aw_a >= STACK && aw_a < STACK + 'h10000) ent_aw = 1;
        checks++;
        if (awsize !== 3'd1 || wlast !== 1'b1) begin
          failures++;
          $display("FAIL aw_attr awsize=%0d wlast=%b exp=1/1", awsize, wlast);
        end
      end
      if (wvalid && wready) begin
        w_got = 1; w_d = wdata;
      end
      if (aw_got && w_got && !b_pend) begin
        mem16[aw_a] = w_d; b_pend = 1; b_wait = b_delay;
      end
      if (bvalid && bready) begin
        b_pend = 0; aw_got = 0; w_got = 0;
      end
    end
  end

  task automatic load_block(input logic [15:0] c, input logic [7:0] pm);
    logic [99:0] t;
    for (int i = 0; i < 8; i++) begin
      t = {c, 8'(i), 44'h0, 32'($urandom)};
      spill_mem[longint'(c) * 8 + i] = {27'd0, pm[i], t};
      if (!pm[i]) exp_q.push_back(t);
    end
  endtask

  task automatic offer(input logic [15:0] c, output bit ok);
    ok = 0;
    @(negedge clk);
    task_in_locale = {c, 16'h0};
    task_in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      #2;
      if (task_in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    task_in_valid = 0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1; start = 1; task_in_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    checks++;
    if ({busy, stack_lock_out, task_in_ready, arvalid, rready, awvalid,
         wvalid, bready, out_valid} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0", {busy, stack_lock_out,
               task_in_ready, arvalid, rready, awvalid, wvalid, bready, out_valid});
    end
    @(posedge clk); #1;
    rst = 0; task_in_valid = 0;
    @(negedge clk); #2;
    checks++;
    if (busy !== 1'b0 || task_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset busy=%b ready=%b exp=0/1", busy, task_in_ready);
    end
  endtask

  task automatic test_stream;
    bit ok1, ok2;
    int ar0, aw0;
    mem16[longint'(SCR)] = 16'd0;
    ar0 = ar_cnt; aw0 = aw_cnt; emit_cnt = 0; lock_seen = 0;
    load_block(16'd5, 8'b0100_0100);
    offer(16'd5, ok1);
    wait_idle(ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      failures++; $display("FAIL stream_timeout accept=%b idle=%b", ok1, ok2);
    end
    checks++;
    if (sp_araddr !== 64'(SPILL + 38'h280) || sp_arlen !== 8'd7 || sp_arsize !== 3'd4) begin
      failures++;
      $display("FAIL block_ar got=%h/%0d/%0d exp=%h/7/4", sp_araddr, sp_arlen,
               sp_arsize, SPILL + 38'h280);
    end
    checks++;
    if (emit_cnt != 6 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_count got=%0d left=%0d exp=6/0", emit_cnt, exp_q.size());
    end
    checks++;
    if (mem16[longint'(SCR)] !== 16'd1) begin
      failures++; $display("FAIL scr_cnt got=%0d exp=1", mem16[longint'(SCR)]);
    end
    checks++;
    if (lock_seen || ar_cnt - ar0 != 2 || aw_cnt - aw0 != 1) begin
      failures++;
      $display("FAIL stream_traffic lock=%b ar=%0d aw=%0d exp=0/2/1",
               lock_seen, ar_cnt - ar0, aw_cnt - aw0);
    end
  endtask

  task automatic test_backpressure;
    bit ok1, ok2;
    emit_cnt = 0;
    tog_en = 1;
    load_block(16'd5, 8'b0100_0100);
    offer(16'd5, ok1);
    wait_idle(ok2);
    tog_en = 0;
    checks++;
    if (!(ok1 && ok2) || emit_cnt != 6 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_stream ok=%b%b emitted=%0d left=%0d exp=6/0",
               ok1, ok2, emit_cnt, exp_q.size());
    end
    checks++;
    if (mem16[longint'(SCR)] !== 16'd2) begin
      failures++; $display("FAIL bp_scr got=%0d exp=2", mem16[longint'(SCR)]);
    end
  endtask

  task automatic test_all_pad;
    bit ok1, ok2;
    emit_cnt = 0;
    load_block(16'd1, 8'hFF);
    offer(16'd1, ok1);
    wait_idle(ok2);
    checks++;
    if (!(ok1 && ok2) || emit_cnt != 0 || mem16[longint'(SCR)] !== 16'd3) begin
      failures++;
      $display("FAIL all_pad ok=%b%b emitted=%0d cnt=%0d exp=0/3",
               ok1, ok2, emit_cnt, mem16[longint'(SCR)]);
    end
  endtask

  task automatic test_chunk_wrap;
    bit ok1, ok2;
    int aw0;
    mem16[longint'(SCR) + 4] = 16'd7;
    mem16[longint'(PTR)] = 16'd10;
    mem16[longint'(STACK) + 18] = 16'hFFFF;
    viol = 0; lock_seen = 0; aw0 = aw_cnt;
    load_block(16'h17, 8'h81);
    offer(16'h17, ok1);
    wait_idle(ok2);
    checks++;
    if (!(ok1 && ok2) || mem16[longint'(SCR) + 4] !== 16'd0) begin
      failures++;
      $display("FAIL wrap_cnt ok=%b%b got=%0d exp=0", ok1, ok2,
               mem16[longint'(SCR) + 4]);
    end
    checks++;
    if (mem16[longint'(STACK) + 18] !== 16'd2) begin
      failures++;
      $display("FAIL wrap_entry got=%0d exp=2", mem16[longint'(STACK) + 18]);
    end
    checks++;
    if (mem16[longint'(PTR)] !== 16'd9) begin
      failures++; $display("FAIL wrap_ptr got=%0d exp=9", mem16[longint'(PTR)]);
    end
    checks++;
    if (viol != 0 || !lock_seen || stack_lock_out !== 1'b0 || aw_cnt - aw0 != 3) begin
      failures++;
      $display("FAIL wrap_lock viol=%0d seen=%b lock=%b aw=%0d exp=0/1/0/3",
               viol, lock_seen, stack_lock_out, aw_cnt - aw0);
    end
  endtask

  task automatic test_lock_contention;
    bit ok1, ok2, ok3;
    int ar0, aw0, bad;
    mem16[longint'(SCR) + 8] = 16'd7;
    mem16[longint'(PTR)] = 16'd20;
    mem16[longint'(STACK) + 38] = 16'hFFFF;
    viol = 0; emit_cnt = 0;
    stack_lock_in = 1;
    load_block(16'h27, 8'h00);
    offer(16'h27, ok1);
    ok2 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (mem16[longint'(SCR) + 8] === 16'd0) begin ok2 = 1; break; end
    end
    checks++;
    if (!(ok1 && ok2) || emit_cnt != 8) begin
      failures++;
      $display("FAIL lock_pre ok=%b%b emitted=%0d exp=8", ok1, ok2, emit_cnt);
    end
    ar0 = ar_cnt; aw0 = aw_cnt; bad = 0;
    repeat (20) begin
      @(negedge clk); #2;
      if (stack_lock_out || !busy) bad++;
    end
    checks++;
    if (bad != 0 || ar_cnt != ar0 || aw_cnt != aw0) begin
      failures++;
      $display("FAIL lock_wait bad=%0d ar=%0d aw=%0d exp=0/0/0",
               bad, ar_cnt - ar0, aw_cnt - aw0);
    end
    @(negedge clk);
    stack_lock_in = 0;
    @(posedge clk); #1;
    stack_lock_in = 1;
    @(negedge clk); #2;
    checks++;
    if (stack_lock_out !== 1'b1) begin
      failures++; $display("FAIL lock_grab got=%b exp=1", stack_lock_out);
    end
    wait_idle(ok3);
    checks++;
    if (!ok3 || mem16[longint'(PTR)] !== 16'd19 ||
        mem16[longint'(STACK) + 38] !== 16'd4 || viol != 0) begin
      failures++;
      $display("FAIL lock_push ok=%b ptr=%0d ent=%0d viol=%0d exp=1/19/4/0",
               ok3, mem16[longint'(PTR)], mem16[longint'(STACK) + 38], viol);
    end
    stack_lock_in = 0;
  endtask

  task automatic test_reset_mid;
    bit ok1, ok2;
    mem16[longint'(SCR) + 12] = 16'd7;
    mem16[longint'(PTR)] = 16'd30;
    b_delay = 6; ent_aw = 0;
    load_block(16'h37, 8'hFF);
    offer(16'h37, ok1);
    ok2 = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (ent_aw) begin ok2 = 1; break; end
    end
    @(negedge clk); #2;
    checks++;
    if (!(ok1 && ok2) || bready !== 1'b1 || stack_lock_out !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre ok=%b%b bready=%b lock=%b exp=1/1", ok1, ok2,
               bready, stack_lock_out);
    end
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({busy, stack_lock_out, arvalid, awvalid, wvalid, out_valid,
         task_in_ready, bready, rready} !== 9'd0) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=0", {busy, stack_lock_out, arvalid,
               awvalid, wvalid, out_valid, task_in_ready, bready, rready});
    end
    @(posedge clk); #1;
    rst = 0; b_delay = 0;
    @(negedge clk); #2;
    checks++;
    if (busy !== 1'b0 || stack_lock_out !== 1'b0 || mem16[longint'(PTR)] !== 16'd30) begin
      failures++;
      $display("FAIL mid_after busy=%b lock=%b ptr=%0d exp=0/0/30", busy,
               stack_lock_out, mem16[longint'(PTR)]);
    end
  endtask

  task automatic test_start_low;
    int ar0, aw0, bad;
    start = 0;
    ar0 = ar_cnt; aw0 = aw_cnt; bad = 0;
    @(negedge clk);
    task_in_locale = {16'd5, 16'h0};
    task_in_valid = 1;
    repeat (20) begin
      @(negedge clk); #2;
      if (task_in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    task_in_valid = 0;
    checks++;
    if (bad != 0 || ar_cnt != ar0 || aw_cnt != aw0) begin
      failures++;
      $display("FAIL start_low bad=%0d ar=%0d aw=%0d exp=0/0/0", bad,
               ar_cnt - ar0, aw_cnt - aw0);
    end
    start = 1;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_all_pad;
    test_chunk_wrap;
    test_lock_contention;
    test_reset_mid;
    test_start_low;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
